sim_halt_ctrl: RTL

Simulation end-of-run controller for the NPC core. It watches the commit stream for `ebreak` (32'h0010_0073) and freezes instruction fetch. It drains the pipeline for a fixed number of cycles, captures the `a0` exit code, and raises a single `halt_done` pulse for the testbench to call `$finish`. It replaces ad-hoc combinational ebreak detection in the sim top with a clocked, deterministic halt sequence and an optional cycle watchdog.

---
 rtl/sim_pkg.sv | 13 +
 rtl/sim_halt_ctrl_if.sv | 10 +
 rtl/sim_halt_ctrl_sat_counter.sv | 19 +
 rtl/sim_halt_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/sim_pkg.sv
// Shared types and constants for the simulation halt controller.
package sim_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

  localparam logic [31:0] INST_EBREAK  = 32'h0010_0073;
  localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/sim_halt_ctrl_if.sv
// Commit stream from the core's retire stage into the halt controller.
interface sim_halt_ctrl_if;
  logic        commit_valid;
  logic [31:0] commit_inst;
  logic [31:0] commit_pc;
  logic [31:0] a0_value;

  modport master (output commit_valid, commit_inst, commit_pc, a0_value);
  modport slave  (input  commit_valid, commit_inst, commit_pc, a0_value);
endinterface

// File: rtl/sim_halt_ctrl_sat_counter.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sim_halt_ctrl.sv
// End-of-run controller: ebreak commit -> freeze fetch -> drain -> one halt_done pulse.
// Optional cycle watchdog enabled by defining SIM_HALT_WATCHDOG_EN.
//
// state  | meaning
// RUN    | normal execution, watching commits for ebreak (and watchdog limit)
// DRAIN  | halt_req high, counting down drain_cnt while older work retires
// HALTED | terminal until reset; outputs hold, halt_done already pulsed
module sim_halt_ctrl
  import sim_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES   = 32'd1_000_000,
  parameter int          CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  sim_halt_ctrl_if.slave   commit,
  output logic             halt_req,
  output logic             halt_done,
  output logic [31:0]      exit_code,
  output logic [31:0]      halt_pc,
  output logic             good_trap,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  halt_state_e   state;
  logic [DW-1:0] drain_cnt;
  logic          is_ebreak;

  assign is_ebreak = commit.commit_valid && (commit.commit_inst == INST_EBREAK);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (state != HALTED),
    .count   (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (commit.commit_valid),
    .count   (retire_cnt)
  );

`ifdef SIM_HALT_WATCHDOG_EN
  logic [31:0] last_pc;
  logic        wd_hit;

  assign wd_hit = (cycle_cnt == CNT_W'(MAX_CYCLES - 32'd1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_pc <= '0;
    end else if (commit.commit_valid) begin
      last_pc <= commit.commit_pc;
    end
  end
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      drain_cnt <= '0;
      halt_req  <= 1'b0;
      halt_done <= 1'b0;
      exit_code <= '0;
      halt_pc   <= '0;
      good_trap <= 1'b0;
`ifdef SIM_HALT_WATCHDOG_EN
      timeout   <= 1'b0;
`endif
    end else begin
      halt_done <= 1'b0;
      unique case (state)
        RUN: begin
          // ebreak is checked first so it wins over a same-cycle watchdog hit
          if (is_ebreak) begin
            exit_code <= commit.a0_value;
            halt_pc   <= commit.commit_pc;
            good_trap <= (commit.a0_value == 32'd0);
            halt_req  <= 1'b1;
`ifdef SIM_HALT_WATCHDOG_EN
            timeout   <= 1'b0;
`endif
            if (DRAIN_CYCLES == 0) begin
              state     <= HALTED;
              halt_done <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
`ifdef SIM_HALT_WATCHDOG_EN
          else if (wd_hit) begin
            exit_code <= TIMEOUT_CODE;
            halt_pc   <= commit.commit_valid ? commit.commit_pc : last_pc;
            good_trap <= 1'b0;
            halt_req  <= 1'b1;
            timeout   <= 1'b1;
            if (DRAIN_CYCLES == 0) begin
              state     <= HALTED;
              halt_done <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
`endif
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state     <= HALTED;
            halt_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        HALTED: begin
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
